tdm_mux4x1: RTL and testbench
=============================

TDM_MUX4X1 -- requirements
Module: tdm_mux4x1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every channel and of the output.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  4  per-channel beat valid; bit i belongs to channel i.
REQ-005 in_data  input  4*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
REQ-006 in_last  input  4  per-channel last beat of packet.
REQ-007 in_ready  output  4  per-channel accept; combinational.
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  WIDTH  registered output data.
REQ-010 out_sel  output  2  registered source channel index; drives s1 (bit 1) and s0 (bit 0) of the downstream demux4x1.
REQ-011 out_last  output  1  registered last flag of the output beat.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 busy  output  1  high while a packet lock is held (state LOCKED).

Function
REQ-014 Input beat i SHALL transfer when in_valid[i] and in_ready[i] are both high at a rising edge; output beat transfers when out_valid and out_ready are both high.
REQ-015 can_load = !out_valid || out_ready; in_ready SHALL be one-hot or zero, asserted only on the granted channel and only when can_load is high.
REQ-016 FSM states: IDLE and LOCKED; busy = (state == LOCKED).
REQ-017 IDLE grant: first channel with in_valid high, searching rr_ptr, rr_ptr+1, ... mod 4; no request means no grant.
REQ-018 LOCKED grant: lock_ch only; other channels SHALL see in_ready = 0 regardless of in_valid.
REQ-019 Accepted beat with in_last = 0 from IDLE: go to LOCKED, lock_ch = granted index.
REQ-020 Accepted beat with in_last = 1 (from either state): go to/stay in IDLE, rr_ptr = granted index + 1 mod 4.
REQ-021 rr_ptr and state SHALL not change in a cycle with no input transfer.
REQ-022 Latency: an accepted input beat SHALL appear on out_data/out_sel/out_last with out_valid high on the next cycle.
REQ-023 out_valid high with out_ready low: out_data, out_sel and out_last SHALL hold stable; no input is accepted.
REQ-024 Output transfer and new input load in the same cycle SHALL be supported: one beat per cycle sustained throughput.
REQ-025 Output transfer with no new load: out_valid SHALL clear the next cycle; out_data/out_sel/out_last keep their last values.
REQ-026 Packets from different channels SHALL never interleave on the output; beat order within a channel SHALL be preserved.
REQ-027 in_valid dropping on lock_ch mid-packet: SHALL stay LOCKED, output idles, other channels wait.

Reset
REQ-028 rst_n low SHALL immediately force out_valid = 0, out_data = 0, out_sel = 0, out_last = 0, busy = 0, in_ready = 0, state = IDLE, rr_ptr = 0.
REQ-029 Reset mid-packet SHALL drop the lock and any held output beat; no partial-packet recovery is performed.
REQ-030 First grant after reset release SHALL use rr_ptr = 0.

Verification
REQ-031 Single beats: after reset, in_valid = 4'b1111, all in_last = 1, data i = 8'hA0+i, out_ready = 1 -> out_sel 0,1,2,3,0 on consecutive cycles with matching data, no gaps.
REQ-032 Packet lock: ch2 sends 3 beats (last on 3rd) while ch0 and ch1 request -> out_sel = 2 for 3 beats, busy high until 3rd accept, then ch0 then ch1 (rr_ptr = 3 wraps).
REQ-033 Backpressure: out_ready = 0 for 4 cycles with out_valid high, data 8'h5C -> out_data/out_sel stable, in_ready = 4'b0000; out_ready = 1 -> exactly one 8'h5C beat transfers.
REQ-034 Stall in lock: ch1 sends a non-last beat then deasserts in_valid for 5 cycles while ch3 requests -> in_ready[3] = 0 throughout, busy = 1; ch1 resumes with last -> ch3 granted next.
REQ-035 Reset mid-packet: assert rst_n = 0 during LOCKED with out_valid = 1 -> all outputs 0 asynchronously; after release ch0 wins a 4-way request.
REQ-036 Demux loopback: out_data[0]/out_sel drive a demux4x1 din/s1/s0 -> output yi follows the channel i beat bit 0 exactly when out_sel = i.

Source files
------------

// File: rtl/tdm_mux4x1_if.sv
`default_nettype none
// ============================================================================
// tdm_mux4x1_if : 4-channel input / single TDM output bundle for tdm_mux4x1
// Rev 1.0
// ============================================================================
interface tdm_mux4x1_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_last;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_last;
    logic               out_ready;
    logic               busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/tdm_mux4x1.sv
`default_nettype none
// ============================================================================
// tdm_mux4x1 : round-robin, packet-locked 4:1 TDM multiplexer, 1-deep output
// Rev 1.0
// ============================================================================
module tdm_mux4x1 #(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    tdm_mux4x1_if.slave bus
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_lock_ch;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;
    logic             r_out_last;

    logic             w_can_load;
    logic             w_gnt_valid;
    logic [1:0]       w_gnt;
    logic [1:0]       w_idx;
    logic [3:0]       w_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data_sel;
    logic             w_last_sel;

    assign w_can_load = !r_out_valid || bus.out_ready;

    // Descending scan so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        w_gnt       = r_rr_ptr;
        w_gnt_valid = 1'b0;
        w_idx       = '0;
        if (r_state == S_LOCKED) begin
            w_gnt       = r_lock_ch;
            w_gnt_valid = 1'b1;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                w_idx = r_rr_ptr + 2'(k);
                if (bus.in_valid[w_idx]) begin
                    w_gnt       = w_idx;
                    w_gnt_valid = 1'b1;
                end
            end
        end
    end

    // rst_n gates ready so it drops immediately, not only at the next edge.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_can_load && w_gnt_valid) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_xfer     = bus.in_valid[w_gnt] && w_ready[w_gnt];
    assign w_data_sel = bus.in_data[w_gnt*WIDTH +: WIDTH];
    assign w_last_sel = bus.in_last[w_gnt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_lock_ch   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data_sel;
                r_out_sel   <= w_gnt;
                r_out_last  <= w_last_sel;
                if (w_last_sel) begin
                    r_state  <= S_IDLE;
                    r_rr_ptr <= w_gnt + 2'd1;
                end else if (r_state == S_IDLE) begin
                    r_state   <= S_LOCKED;
                    r_lock_ch <= w_gnt;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state == S_LOCKED);
endmodule
`default_nettype wire

// File: tb/tb_tdm_mux4x1.sv
`default_nettype none
// ============================================================================
// tb_tdm_mux4x1 : directed stimulus with queue scoreboard and output monitor
// Rev 1.0
// ============================================================================
module tb_tdm_mux4x1;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic  clk;
    logic  rst_n;
    int    n_checks;
    int    n_fail;
    beat_t sb_q[$];
    logic [3:0] y;

    tdm_mux4x1_if #(.WIDTH(WIDTH)) bus ();

    tdm_mux4x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream demux4x1 driven by out_data[0] (din), out_sel[1] (s1), out_sel[0] (s0)
    always_comb begin
        y = '0;
        y[bus.out_sel] = bus.out_data[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d, input logic l);
        beat_t b;
        b.sel  = s;
        b.data = d;
        b.last = l;
        sb_q.push_back(b);
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    // Monitor: every output transfer is popped and compared
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            beat_t e;
            logic [3:0] exp_y;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got sel=%0d data=%h, expected no beat", bus.out_sel, bus.out_data);
            end else begin
                e = sb_q.pop_front();
                if ({bus.out_sel, bus.out_data, bus.out_last} !== {e.sel, e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL sb_beat: got sel=%0d data=%h last=%b expected sel=%0d data=%h last=%b",
                             bus.out_sel, bus.out_data, bus.out_last, e.sel, e.data, e.last);
                end
                exp_y = '0;
                exp_y[e.sel] = e.data[0];
                n_checks++;
                if (y !== exp_y) begin
                    n_fail++;
                    $display("FAIL demux_y: got %b expected %b", y, exp_y);
                end
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single beats, all channels, full throughput
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        push(2'd0, 8'hA0, 1'b1);
        push(2'd1, 8'hA1, 1'b1);
        push(2'd2, 8'hA2, 1'b1);
        push(2'd3, 8'hA3, 1'b1);
        push(2'd0, 8'hA0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t1_out_sel",   32'(bus.out_sel),   32'(i % 4));
        end
        bus.in_valid = '0;
        tick();
        tick();

        // Packet lock on ch2 while ch0/ch1 request; rr_ptr = 1 here
        bus.in_valid = 4'b0100;
        bus.in_last  = 4'b0000;
        set_data(8'hB0, 8'hB1, 8'h21, 8'h00);
        push(2'd2, 8'h21, 1'b0);
        tick();
        chk("t2_busy_1", 32'(bus.busy), 32'd1);
        bus.in_valid = 4'b0111;
        bus.in_last  = 4'b0011;
        set_data(8'hB0, 8'hB1, 8'h22, 8'h00);
        #1;
        chk("t2_in_ready_lock", 32'(bus.in_ready), 32'b0100);
        push(2'd2, 8'h22, 1'b0);
        tick();
        chk("t2_busy_2", 32'(bus.busy), 32'd1);
        set_data(8'hB0, 8'hB1, 8'h23, 8'h00);
        bus.in_last = 4'b0111;
        push(2'd2, 8'h23, 1'b1);
        tick();
        chk("t2_busy_3", 32'(bus.busy), 32'd0);
        bus.in_valid = 4'b0011;
        push(2'd0, 8'hB0, 1'b1);
        push(2'd1, 8'hB1, 1'b1);
        tick();
        bus.in_valid = 4'b0010;
        tick();
        bus.in_valid = '0;
        tick();
        tick();

        // Backpressure; rr_ptr = 2 here
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0001;
        bus.in_last   = 4'b0001;
        set_data(8'h5C, 8'h00, 8'h00, 8'h00);
        push(2'd0, 8'h5C, 1'b1);
        tick();
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b1000;
        set_data(8'h00, 8'h00, 8'h00, 8'h99);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_out_data",  32'(bus.out_data),  32'h5C);
            chk("t3_out_sel",   32'(bus.out_sel),   32'd0);
            chk("t3_in_ready",  32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        tick();
        chk("t3_one_beat", 32'(bus.out_valid), 32'd0);
        tick();

        // Stall inside a ch1 packet while ch3 requests; rr_ptr = 1 here
        bus.in_valid = 4'b0010;
        bus.in_last  = 4'b0000;
        set_data(8'h00, 8'h41, 8'h00, 8'h00);
        push(2'd1, 8'h41, 1'b0);
        tick();
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b1000;
        set_data(8'h00, 8'h00, 8'h00, 8'h33);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_in_ready3", 32'(bus.in_ready[3]), 32'd0);
            chk("t4_busy",      32'(bus.busy),        32'd1);
            tick();
        end
        chk("t4_out_idle", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 4'b1010;
        bus.in_last  = 4'b1010;
        set_data(8'h00, 8'h42, 8'h00, 8'h33);
        #1;
        chk("t4_in_ready_resume", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 8'h42, 1'b1);
        tick();
        bus.in_valid = 4'b1000;
        push(2'd3, 8'h33, 1'b1);
        tick();
        bus.in_valid = '0;
        tick();
        tick();

        // Reset while locked on ch1 with a held output beat
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        bus.in_last   = 4'b0000;
        set_data(8'h00, 8'h51, 8'h00, 8'h00);
        tick();
        chk("t5_pre_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n         = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b1111;
        bus.out_ready = 1'b1;
        set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        #1;
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_out_data",  32'(bus.out_data),  32'd0);
        chk("t5_out_sel",   32'(bus.out_sel),   32'd0);
        chk("t5_out_last",  32'(bus.out_last),  32'd0);
        chk("t5_busy",      32'(bus.busy),      32'd0);
        chk("t5_in_ready",  32'(bus.in_ready),  32'd0);
        push(2'd0, 8'hC0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.in_valid = '0;
        tick();
        tick();

        // Demux loopback with mixed bit-0 data; rr_ptr = 1 here
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b1111;
        set_data(8'h01, 8'h02, 8'h03, 8'h04);
        push(2'd1, 8'h02, 1'b1);
        push(2'd2, 8'h03, 1'b1);
        push(2'd3, 8'h04, 1'b1);
        push(2'd0, 8'h01, 1'b1);
        repeat (4) tick();
        bus.in_valid = '0;

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
